// File: rtl/mux4_scan_ctrl_sar.sv
// Sweep controller for an external 4:1 mux: steps {S1,S0} over the enabled channels and samples MUX_OUT into RESULT.
// Optional continuous mode (restart straight from FINISH while START is high) is enabled by defining MUX4_SCAN_CONT_EN.
module mux4_scan_ctrl_sar #(
    parameter int DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [3:0]         ch_mask_i,
    input  logic               mux_out_i,
    output logic               s1_o,
    output logic               s0_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         result_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FINISH = 2'd2} state_e;

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         result_q, result_d;

    logic               accept;
    logic               next_ok;
    logic [1:0]         next_ch;
    logic [1:0]         first_ch;
    logic [DWELL_W-1:0] cnt_last;

    // DWELL of 0 behaves as 1, so the counter tops out at 2^DWELL_W-2 and never wraps.
    assign cnt_last = (dwell_q == '0) ? '0 : (dwell_q - ONE);

    always_comb begin
        next_ok  = 1'b0;
        next_ch  = 2'b00;
        first_ch = 2'b00;
        for (int n = 3; n >= 0; n--) begin
            if (n > int'(sel_q) && mask_q[n]) begin
                next_ok = 1'b1;
                next_ch = 2'(n);
            end
            if (ch_mask_i[n]) begin
                first_ch = 2'(n);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        result_d = result_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d  = 2'b00;
                accept = start_i;
            end
            SCAN: begin
                if (cnt_q == cnt_last) begin
                    result_d[sel_q] = mux_out_i;
                    cnt_d           = '0;
                    if (next_ok) begin
                        sel_d = next_ch;
                    end else begin
                        sel_d   = 2'b00;
                        state_d = FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            FINISH: begin
                state_d = IDLE;
`ifdef MUX4_SCAN_CONT_EN
                accept  = start_i;
`endif
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
            end
        endcase
        if (accept) begin
            result_d = 4'b0000;
            dwell_d  = dwell_i;
            mask_d   = ch_mask_i;
            cnt_d    = '0;
            if (ch_mask_i != 4'b0000) begin
                state_d = SCAN;
                sel_d   = first_ch;
            end else begin
                state_d = FINISH;
                sel_d   = 2'b00;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            sel_q    <= 2'b00;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= 4'b0000;
            result_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            result_q <= result_d;
        end
    end

    assign s1_o     = sel_q[1];
    assign s0_o     = sel_q[0];
    assign busy_o   = (state_q == SCAN);
    assign done_o   = (state_q == FINISH);
    assign result_o = result_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mux4_scan_ctrl_sar.sv
// Directed bench for mux4_scan_ctrl_sar; the downstream 4:1 mux is modelled from in_vec and the DUT selects.
module tb_mux4_scan_ctrl_sar;

    localparam int DW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] dwell_i = '0;
    logic [3:0]    ch_mask_i = 4'b0000;
    logic          mux_out_i;
    logic          s1_o, s0_o, busy_o, done_o;
    logic [3:0]    result_o;
    logic [1:0]    state_o;

    logic [3:0]    in_vec = 4'b0101;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            lat;
    int            nd;
    logic [1:0]    seq27 [8];

    mux4_scan_ctrl_sar #(.DWELL_W(DW)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .dwell_i   (dwell_i),
        .ch_mask_i (ch_mask_i),
        .mux_out_i (mux_out_i),
        .s1_o      (s1_o),
        .s0_o      (s0_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .state_o   (state_o)
    );

    assign mux_out_i = in_vec[{s1_o, s0_o}];

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Accepting edge is cycle 0; returns sampling inside cycle 1.
    task automatic launch(input logic [3:0] mask, input logic [DW-1:0] dw);
        ch_mask_i = mask;
        dwell_i   = dw;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        cyc     = 1;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            if (done_o) begin
                at = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (done_o) cnt++;
        end
    endtask

    initial begin
        seq27 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outputs", {s1_o, s0_o, busy_o, done_o, result_o}, 8'h00);
        rst_n_i = 1'b1;
        tick();
        check("idle_state", state_o, 2'd0);

        // Full mask, DWELL=2: select sequence, DONE timing, RESULT.
        in_vec = 4'b0101;
        launch(4'b1111, 4'd2);
        for (int i = 0; i < 8; i++) begin
            check("seq27_sel", {s1_o, s0_o}, seq27[i]);
            check("seq27_busy", {busy_o, done_o}, 2'b10);
            tick();
        end
        check("seq27_done", {busy_o, done_o}, 2'b01);
        check("seq27_result", result_o, 4'b0101);
        tick();
        check("seq27_after", {s1_o, s0_o, busy_o, done_o}, 4'b0000);
        check("seq27_hold", result_o, 4'b0101);

        // Sparse mask 1010, DWELL=1.
        tick();
        launch(4'b1010, 4'd1);
        check("m1010_sel1", {s1_o, s0_o}, 2'b01);
        tick();
        check("m1010_sel2", {s1_o, s0_o}, 2'b11);
        wait_done(50, lat);
        check("m1010_lat", lat, 3);
        check("m1010_result", result_o, 4'b0000);
        tick();
        in_vec = 4'b0111;
        launch(4'b1010, 4'd1);
        wait_done(50, lat);
        check("m1010_in1_result", result_o, 4'b0010);

        // Empty mask: immediate DONE, no BUSY, RESULT cleared.
        tick();
        launch(4'b0000, 4'd3);
        check("m0_done", {busy_o, done_o}, 2'b01);
        check("m0_result", result_o, 4'b0000);
        tick();
        check("m0_idle", {busy_o, done_o}, 2'b00);

        // DWELL=0 acts as one cycle.
        tick();
        launch(4'b0001, 4'd0);
        wait_done(50, lat);
        check("dw0_lat", lat, 2);
        check("dw0_result", result_o, 4'b0001);

        // Maximum dwell on the top channel.
        tick();
        in_vec = 4'b1000;
        launch(4'b1000, 4'd15);
        check("dw15_sel", {s1_o, s0_o}, 2'b11);
        wait_done(50, lat);
        check("dw15_lat", lat, 16);
        check("dw15_result", result_o, 4'b1000);

        // Mid-sweep START and input changes must not disturb the sweep.
        tick();
        in_vec = 4'b0101;
        launch(4'b1111, 4'd2);
        tick();
        tick();
        start_i   = 1'b1;
        ch_mask_i = 4'b0000;
        dwell_i   = 4'd7;
        tick();
        start_i = 1'b0;
        wait_done(50, lat);
        check("dist_lat", lat, 9);
        check("dist_result", result_o, 4'b0101);
        count_done(25, nd);
        check("dist_single_done", nd, 0);

        // Reset asserted at cycle 4 of a sweep.
        launch(4'b1111, 4'd2);
        tick();
        tick();
        tick();
        rst_n_i = 1'b0;
        #1;
        check("midrst_outputs", {s1_o, s0_o, busy_o, done_o, result_o}, 8'h00);
        tick();
        rst_n_i = 1'b1;
        count_done(20, nd);
        check("midrst_no_done", nd, 0);
        launch(4'b1111, 4'd2);
        wait_done(50, lat);
        check("midrst_fresh_lat", lat, 9);
        check("midrst_fresh_result", result_o, 4'b0101);

        // START held high through FINISH.
        tick();
        ch_mask_i = 4'b1111;
        dwell_i   = 4'd2;
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        cyc = 1;
        wait_done(50, lat);
        check("hold_done1", lat, 9);
        check("hold_result1", result_o, 4'b0101);
`ifdef MUX4_SCAN_CONT_EN
        tick();
        check("cont_busy_back", busy_o, 1'b1);
        wait_done(50, lat);
        check("cont_done2", lat, 18);
        check("cont_result2", result_o, 4'b0101);
        tick();
        wait_done(50, lat);
        check("cont_done3", lat, 27);
        check("cont_result3", result_o, 4'b0101);
        start_i = 1'b0;
        tick();
        check("cont_stop", {busy_o, done_o}, 2'b00);
`else
        tick();
        start_i = 1'b0;
        check("noncont_idle", state_o, 2'd0);
        check("noncont_flags", {busy_o, done_o}, 2'b00);
        count_done(25, nd);
        check("noncont_single_done", nd, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
